// File: rtl/load_store_unit_if.sv
// Load/store request bus plus data-memory port B.
// master: the side issuing requests and hosting memory port B.
// slave : the load_store_unit itself.
interface load_store_unit_if;
  logic        lsu_request_valid;
  logic        lsu_request_ready;
  logic        lsu_write;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_address;
  logic [31:0] lsu_store_data;
  logic [31:0] lsu_load_data;
  logic        lsu_done;
  logic        lsu_fault;
  logic        memory_write_enable_b;
  logic [31:0] memory_access_address_b;
  logic [31:0] memory_write_data_b;
  logic [31:0] memory_read_data_b;

  modport master (
    output lsu_request_valid, lsu_write, lsu_funct3, lsu_address, lsu_store_data,
    output memory_read_data_b,
    input  lsu_request_ready, lsu_load_data, lsu_done, lsu_fault,
    input  memory_write_enable_b, memory_access_address_b, memory_write_data_b
  );

  modport slave (
    input  lsu_request_valid, lsu_write, lsu_funct3, lsu_address, lsu_store_data,
    input  memory_read_data_b,
    output lsu_request_ready, lsu_load_data, lsu_done, lsu_fault,
    output memory_write_enable_b, memory_access_address_b, memory_write_data_b
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: byte-addressed loads/stores onto a word-wide
// memory port B. Sub-word stores use read-modify-write.
// Optional feature: define WAVERV_LSU_MISALIGN_CHECK_EN to fault misaligned
// H/HU/W accesses; otherwise such addresses are forced to natural alignment.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESPOND,
    S_FAULT
  } state_e;

  localparam logic [1:0] LAST_READ = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_legal;
  logic        req_fault;
  logic [31:0] req_addr;
`ifdef WAVERV_LSU_MISALIGN_CHECK_EN
  logic        req_misaligned;
`endif

  // Select the addressed lane and sign- or zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  offset);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {offset, 3'b000};
    case (funct3)
      3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  result = {24'h000000, shifted[7:0]};
      3'b101:  result = {16'h0000, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace the addressed byte/half lane of the read word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset);
    logic [31:0] merged;
    merged = word;
    case (size)
      2'b00:   merged[{offset, 3'b000} +: 8] = data[7:0];
      2'b01:   merged[{offset[1], 4'b0000} +: 16] = data;
      default: merged = word;
    endcase
    return merged;
  endfunction

  // Classify the incoming request: legality, fault and aligned address.
  always_comb begin
    req_addr = bus.lsu_address;
    if (bus.lsu_write) begin
      req_legal = bus.lsu_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = bus.lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (bus.lsu_funct3[1:0])
      2'b01:   req_addr[0]   = 1'b0;
      2'b10:   req_addr[1:0] = 2'b00;
      default: ;
    endcase
`ifdef WAVERV_LSU_MISALIGN_CHECK_EN
    req_misaligned = ((bus.lsu_funct3[1:0] == 2'b01) && bus.lsu_address[0]) ||
                     ((bus.lsu_funct3[1:0] == 2'b10) && (bus.lsu_address[1:0] != 2'b00));
    req_fault = !req_legal || req_misaligned;
`else
    req_fault = !req_legal;
`endif
  end

  // Next-state and output logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.lsu_request_valid) begin
          write_d  = bus.lsu_write;
          funct3_d = bus.lsu_funct3;
          offset_d = req_addr[1:0];
          sdata_d  = bus.lsu_store_data[15:0];
          cnt_d    = 2'd0;
          if (req_fault) begin
            state_d = S_FAULT;
          end else if (bus.lsu_write && (bus.lsu_funct3[1:0] == 2'b10)) begin
            mem_addr_d  = {2'b00, req_addr[31:2]};
            mem_wdata_d = bus.lsu_store_data;
            state_d     = S_WRITE;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q == LAST_READ) begin
          if (write_q) begin
            mem_wdata_d = merge_store(bus.memory_read_data_b, sdata_q, funct3_q[1:0], offset_q);
            state_d     = S_WRITE;
          end else begin
            load_data_d = extend_load(bus.memory_read_data_b, funct3_q, offset_q);
            state_d     = S_RESPOND;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WRITE:   state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      S_FAULT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    bus.lsu_request_ready       = (state_q == S_IDLE);
    bus.lsu_done                = (state_q == S_RESPOND) || (state_q == S_FAULT);
    bus.lsu_fault               = (state_q == S_FAULT);
    bus.memory_write_enable_b   = (state_q == S_WRITE) && !rst;
    bus.lsu_load_data           = load_data_q;
    bus.memory_access_address_b = mem_addr_q;
    bus.memory_write_data_b     = mem_wdata_q;
  end

  // State and datapath registers; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      sdata_q     <= 16'h0000;
      load_data_q <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      sdata_q     <= sdata_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (READ_LATENCY 1, 2, 4) sharing
// one word memory; vector table, hand sequences and a random phase against
// a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  sel;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] sdata;

  logic [31:0] mem [16];
  logic [31:0] last_ld [3];

  logic [2:0]  rdy_v, done_v, flt_v, we_v;
  logic [31:0] ld_a [3];
  logic [31:0] ma_a [3];
  logic [31:0] wd_a [3];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    load_store_unit_if bus ();
    logic [31:0] rp0, rp1, rp2, rp3;

    assign bus.lsu_request_valid = req_valid && (int'(sel) == g);
    assign bus.lsu_write         = wr;
    assign bus.lsu_funct3        = f3;
    assign bus.lsu_address       = addr;
    assign bus.lsu_store_data    = sdata;

    // memory whose data is valid L-1 cycles after the address settles
    assign rp0 = mem[bus.memory_access_address_b[3:0]];
    always @(posedge clk) begin
      rp1 <= rp0;
      rp2 <= rp1;
      rp3 <= rp2;
    end
    assign bus.memory_read_data_b = (L == 1) ? rp0 : (L == 2) ? rp1 : rp3;

    assign rdy_v[g]  = bus.lsu_request_ready;
    assign done_v[g] = bus.lsu_done;
    assign flt_v[g]  = bus.lsu_fault;
    assign we_v[g]   = bus.memory_write_enable_b;
    assign ld_a[g]   = bus.lsu_load_data;
    assign ma_a[g]   = bus.memory_access_address_b;
    assign wd_a[g]   = bus.memory_write_data_b;

    load_store_unit #(.READ_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  // Reference model from the RV32I access rules, using byte arithmetic.
  function automatic void model(input logic w, input logic [2:0] fn, input logic [31:0] a,
                                input logic [31:0] sd, input int lat, input logic [31:0] prev_ld,
                                output logic e_fault, output int e_wcyc,
                                output logic [31:0] e_waddr, output logic [31:0] e_wdata,
                                output int e_done, output logic [31:0] e_ld);
    int size, off;
    logic legal, mis;
    logic [31:0] ea, word, v, nw;
    size  = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    legal = w ? (fn <= 3'd2) : !(fn == 3'd3 || fn == 3'd6 || fn == 3'd7);
    mis   = (a % size) != 0;
`ifdef WAVERV_LSU_MISALIGN_CHECK_EN
    e_fault = !legal || mis;
`else
    e_fault = !legal;
`endif
    e_wcyc = 0; e_waddr = 0; e_wdata = 0; e_ld = prev_ld; e_done = 1;
    if (e_fault) return;
    ea   = a - (a % size);
    off  = ea % 4;
    word = mem[ea[5:2]];
    if (!w) begin
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!fn[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!fn[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      e_ld = v;
      e_done = lat + 1;
    end else begin
      e_waddr = ea / 4;
      if (size == 4) begin
        e_wdata = sd;
        e_wcyc = 1;
      end else begin
        nw = word;
        for (int b = 0; b < size; b++) begin
          nw = (nw & ~(32'hFF << (8 * (off + b)))) | (((sd >> (8 * b)) & 32'hFF) << (8 * (off + b)));
        end
        e_wdata = nw;
        e_wcyc = lat + 1;
      end
      e_done = e_wcyc + 1;
    end
  endfunction

  // Issue one request (called on a falling edge) and compare the whole transaction.
  task automatic run_req(input int i, input logic w, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] sd, input logic e_fault, input int e_wcyc,
                         input logic [31:0] e_waddr, input logic [31:0] e_wdata,
                         input int e_done, input logic [31:0] e_ld, input string tag);
    int wcount = 0, wcyc = 0, dcyc = 0;
    logic [31:0] waddr = 0, wdata = 0, ldv = 0;
    logic fv = 0, stray = 0;
    sel = 2'(i); wr = w; f3 = fn; addr = a; sdata = sd; req_valid = 1'b1;
    checkb({tag, "/ready"}, rdy_v[i], 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20 && dcyc == 0; k++) begin
      if (we_v[i]) begin wcount++; wcyc = k; waddr = ma_a[i]; wdata = wd_a[i]; end
      if (flt_v[i] && !done_v[i]) stray = 1'b1;
      if (done_v[i]) begin dcyc = k; fv = flt_v[i]; ldv = ld_a[i]; end
      @(negedge clk);
    end
    checki({tag, "/done_cycle"}, dcyc, e_done);
    checkb({tag, "/fault"}, fv, e_fault);
    checkb({tag, "/stray_fault"}, stray, 1'b0);
    checki({tag, "/write_count"}, wcount, (e_wcyc != 0) ? 1 : 0);
    if (e_wcyc != 0) begin
      checki({tag, "/write_cycle"}, wcyc, e_wcyc);
      check32({tag, "/write_addr"}, waddr, e_waddr);
      check32({tag, "/write_data"}, wdata, e_wdata);
      mem[e_waddr[3:0]] = e_wdata;
    end
    check32({tag, "/load_data"}, ldv, e_ld);
    checkb({tag, "/ready_after"}, rdy_v[i], 1'b1);
    last_ld[i] = e_ld;
  endtask

  task automatic idle_watch(input int i, input int n, input string tag);
    int hits = 0;
    for (int k = 0; k < n; k++) begin
      if (we_v[i] || done_v[i] || flt_v[i]) hits++;
      @(negedge clk);
    end
    checki({tag, "/no_activity"}, hits, 0);
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    checkb({tag, "/ready"}, rdy_v[i], 1'b1);
    checkb({tag, "/done"}, done_v[i], 1'b0);
    checkb({tag, "/fault"}, flt_v[i], 1'b0);
    checkb({tag, "/we"}, we_v[i], 1'b0);
    check32({tag, "/load_data"}, ld_a[i], 32'h0);
    check32({tag, "/mem_addr"}, ma_a[i], 32'h0);
    check32({tag, "/mem_wdata"}, wd_a[i], 32'h0);
  endtask

  typedef struct {
    int          inst;
    logic        w;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] sd;
    logic        fault;
    int          wcyc;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          done;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic        e_fault;
    int          e_wcyc, e_done, ri;
    logic [31:0] e_waddr, e_wdata, e_ld, ra, rsd;
    logic        rw;
    logic [2:0]  rfn;

    rst = 1'b1; req_valid = 1'b0; sel = 2'd0; wr = 1'b0; f3 = 3'b0; addr = 32'h0; sdata = 32'h0;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    mem[1] = 32'h11223344;
    mem[2] = 32'hDEADBEEF;
    mem[3] = 32'h55667788;
    for (int k = 0; k < 3; k++) last_ld[k] = 32'h0;

    //           inst w     fn      addr    store data    flt  wcyc waddr  wdata          done ld
    tbl[0]  = '{0, 1'b0, 3'b010, 32'h8, 32'h0,        1'b0, 0, 32'h0, 32'h0,         2, 32'hDEADBEEF};
    tbl[1]  = '{0, 1'b0, 3'b000, 32'h9, 32'h0,        1'b0, 0, 32'h0, 32'h0,         2, 32'hFFFFFFBE};
    tbl[2]  = '{0, 1'b0, 3'b100, 32'h9, 32'h0,        1'b0, 0, 32'h0, 32'h0,         2, 32'h000000BE};
    tbl[3]  = '{0, 1'b0, 3'b001, 32'hA, 32'h0,        1'b0, 0, 32'h0, 32'h0,         2, 32'hFFFFDEAD};
    tbl[4]  = '{0, 1'b0, 3'b101, 32'hA, 32'h0,        1'b0, 0, 32'h0, 32'h0,         2, 32'h0000DEAD};
    tbl[5]  = '{1, 1'b1, 3'b000, 32'hA, 32'h12345677, 1'b0, 3, 32'h2, 32'hDE77BEEF,  4, 32'h0};
    tbl[6]  = '{1, 1'b0, 3'b010, 32'h8, 32'h0,        1'b0, 0, 32'h0, 32'h0,         3, 32'hDE77BEEF};
`ifdef WAVERV_LSU_MISALIGN_CHECK_EN
    tbl[7]  = '{0, 1'b1, 3'b010, 32'h6, 32'hCAFEF00D, 1'b1, 0, 32'h0, 32'h0,         1, 32'h0000DEAD};
`else
    tbl[7]  = '{0, 1'b1, 3'b010, 32'h6, 32'hCAFEF00D, 1'b0, 1, 32'h1, 32'hCAFEF00D,  2, 32'h0000DEAD};
`endif
    tbl[8]  = '{0, 1'b0, 3'b011, 32'h8, 32'h0,        1'b1, 0, 32'h0, 32'h0,         1, 32'h0000DEAD};
    tbl[9]  = '{2, 1'b1, 3'b001, 32'hE, 32'h9999ABCD, 1'b0, 5, 32'h3, 32'hABCD7788,  6, 32'h0};
    tbl[10] = '{2, 1'b0, 3'b001, 32'hE, 32'h0,        1'b0, 0, 32'h0, 32'h0,         5, 32'hFFFFABCD};
    tbl[11] = '{1, 1'b1, 3'b100, 32'h8, 32'h0,        1'b1, 0, 32'h0, 32'h0,         1, 32'hDE77BEEF};
`ifdef WAVERV_LSU_MISALIGN_CHECK_EN
    tbl[12] = '{1, 1'b0, 3'b001, 32'h5, 32'h0,        1'b1, 0, 32'h0, 32'h0,         1, 32'hDE77BEEF};
`else
    tbl[12] = '{1, 1'b0, 3'b001, 32'h5, 32'h0,        1'b0, 0, 32'h0, 32'h0,         3, 32'hFFFFF00D};
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) check_reset_outputs(i, $sformatf("reset_l%0d", lat_of(i)));

    for (int v = 0; v < 13; v++) begin
      run_req(tbl[v].inst, tbl[v].w, tbl[v].fn, tbl[v].a, tbl[v].sd, tbl[v].fault, tbl[v].wcyc,
              tbl[v].waddr, tbl[v].wdata, tbl[v].done, tbl[v].ld, $sformatf("vec%0d", v));
    end

    // two LWs with valid held high; address change while busy is ignored
    sel = 2'd0; wr = 1'b0; f3 = 3'b010; addr = 32'h8; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    addr = 32'hC;
    checkb("b2b/busy_t1", rdy_v[0], 1'b0);
    @(negedge clk);
    checkb("b2b/done1", done_v[0], 1'b1);
    check32("b2b/data1", ld_a[0], mem[2]);
    @(negedge clk);
    checkb("b2b/ready_t3", rdy_v[0], 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    checkb("b2b/accepted2", rdy_v[0], 1'b0);
    @(negedge clk);
    checkb("b2b/done2", done_v[0], 1'b1);
    check32("b2b/data2", ld_a[0], mem[3]);
    last_ld[0] = mem[3];
    @(negedge clk);

    // SH on the L=4 lane, reset two cycles after accept
    sel = 2'd2; wr = 1'b1; f3 = 3'b001; addr = 32'h4; sdata = 32'h0000BEEF; req_valid = 1'b1;
    checkb("rst_sh/ready", rdy_v[2], 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    checkb("rst_sh/busy_t1", rdy_v[2], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkb("rst_sh/we_t2", we_v[2], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_ld[i] = 32'h0;
    check_reset_outputs(2, "rst_sh/t3");
    idle_watch(2, 6, "rst_sh");

    // SW on the L=1 lane, reset during its write cycle suppresses the strobe
    sel = 2'd0; wr = 1'b1; f3 = 3'b010; addr = 32'h10; sdata = 32'h5A5A5A5A; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkb("rst_sw/we_gated", we_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checkb("rst_sw/ready", rdy_v[0], 1'b1);
    idle_watch(0, 4, "rst_sw");

    // request coincident with reset is ignored
    sel = 2'd0; wr = 1'b1; f3 = 3'b010; addr = 32'h14; sdata = 32'h0F0F0F0F; req_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    checkb("rst_req/ready", rdy_v[0], 1'b1);
    idle_watch(0, 4, "rst_req");

    // random requests against the reference model
    for (int n = 0; n < 80; n++) begin
      ri  = $urandom_range(0, 2);
      rw  = 1'($urandom_range(0, 1));
      rfn = 3'($urandom_range(0, 7));
      ra  = 32'($urandom_range(0, 63));
      rsd = $urandom;
      model(rw, rfn, ra, rsd, lat_of(ri), last_ld[ri], e_fault, e_wcyc, e_waddr, e_wdata, e_done, e_ld);
      run_req(ri, rw, rfn, ra, rsd, e_fault, e_wcyc, e_waddr, e_wdata, e_done, e_ld,
              $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage for the waverv core. Sits downstream of the ALU: it takes the ALU result as byte address and register read port B as store data, and drives memory port B. It returns sign- or zero-extended load data for register write-back. Sub-word stores use read-modify-write, because memory port B writes only whole 32-bit words.

## Interface
- READ_LATENCY, 1: cycles from address presented to read data valid on memory port B; legal range 1-4.

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- lsu_request_valid  in  1  request present
- lsu_request_ready  out  1  unit idle; request accepted when valid && ready at a rising edge
- lsu_write  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- lsu_address  in  32  byte address (alu_out)
- lsu_store_data  in  32  store data (register_read_data_b); low byte/half used for SB/SH
- lsu_load_data  out  32  extended load result; held until next load completes
- lsu_done  out  1  one-cycle completion pulse
- lsu_fault  out  1  one-cycle pulse coincident with lsu_done; request aborted, no memory access
- memory_write_enable_b  out  1  word write strobe
- memory_access_address_b  out  32  word address, {2'b00, addr[31:2]}
- memory_write_data_b  out  32  word to write
- memory_read_data_b  in  32  word read data

## Operation
- Request fields are captured on accept and are ignored while ready=0.
- Byte lanes are little-endian: byte k is at bits [8k+7:8k], and halfword h is at bits [16h+15:16h].
- FSM states:
  - IDLE: ready=1. On accept:
    - Fault condition → FAULT.
    - Aligned SW → WRITE.
    - Any load, SB or SH → READ.
  - READ: the address is held and the write enable is 0 for READ_LATENCY cycles, counted by a 2-bit counter. On the last cycle the read word is registered.
    - Load → RESPOND.
    - Sub-word store → WRITE, with the merged word: the selected byte/half lanes are replaced by store data and the other lanes are kept.
  - WRITE: memory_write_enable_b=1 for exactly one cycle with address and data → RESPOND.
  - RESPOND: lsu_done=1. For loads, lsu_load_data updates in this cycle. → IDLE.
  - FAULT: lsu_done=1 and lsu_fault=1; lsu_load_data is unchanged. → IDLE.
- Fault conditions:
  - Illegal funct3 (always): loads 011, 110, 111; stores 011, 1xx.
  - Misalignment, when the checking feature is compiled in: H/HU with addr[0]=1; W with addr[1:0]≠0.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- The write enable is never asserted for loads or faults.

## Timing
- Reset values:
  - lsu_request_ready=1 (state IDLE).
  - lsu_done, lsu_fault, memory_write_enable_b = 0.
  - lsu_load_data = 0, memory_access_address_b = 0, memory_write_data_b = 0.
- Cycle latencies, with accept at cycle T and L = READ_LATENCY:
  - SW: write at T+1, done at T+2.
  - Load: read in T+1..T+L, done at T+L+1.
  - SB/SH: read in T+1..T+L, write at T+L+1, done at T+L+2.
  - Fault: done/fault at T+1.
- The next request can be accepted in the cycle after done (ready=1 again). Throughput is 1 request per latency+1 cycles.
- rst is synchronous and has priority over everything. memory_write_enable_b is combinationally gated by !rst, so a WRITE interrupted by reset issues no write. Any in-flight operation is discarded without a done pulse, and the unit returns to IDLE on the following cycle.
- A request presented in the same cycle as rst is ignored.

## Configuration
- WAVERV_LSU_MISALIGN_CHECK_EN defined: misaligned H/HU/W accesses fault as described above, with no memory access.
- Undefined: misaligned accesses proceed with the address forced to natural alignment (addr[0] cleared for H, addr[1:0] cleared for W). lsu_fault is then raised only for illegal funct3.

## Test plan
- L=1, word 2 = 0xDEADBEEF; LW addr 0x8 → no write strobe; done at T+2; lsu_load_data=0xDEADBEEF.
- Same memory; LB addr 0x9 → 0xFFFFFFBE; LBU addr 0x9 → 0x000000BE; LH addr 0xA → 0xFFFFDEAD.
- L=2, word 2 = 0xDEADBEEF; SB addr 0xA, data 0x12345677 → single write of 0xDE77BEEF to word address 2 at T+3; done at T+4.
- With the macro: SW addr 0x6 → fault+done at T+1, no write, ready at T+2. Without the macro: the same request writes word address 1 at T+1.
- SH accepted with L=4; rst asserted at T+2 → no write strobe, no done, ready=1 at T+3, all outputs at reset values.
- lsu_request_valid held high with two LWs → second accepted in the cycle after the first done; both return correct data.
